// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_pkg
// Description : Shared constants, access-size encodings, FSM state type and
//               request-validity helper for the data memory responder.
// Revision    : 1.0  initial release
// ============================================================================
package data_mem_responder_pkg;

    localparam int DMEM_DEPTH = 2048;
    localparam int DMEM_AW    = 11;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        MERGE = 2'd2,
        RESP  = 2'd3
    } state_t;

    // A request is rejected when the decoder flagged it, the size code is the
    // reserved 11, or the access does not sit on its natural boundary.
    function automatic logic req_is_error(input logic       inv,
                                          input logic [1:0] size,
                                          input logic [1:0] off);
        logic bad_size;
        logic misalign;
        bad_size = (size == 2'b11);
        misalign = ((size == SZ_HALF) && off[0]) ||
                   ((size == SZ_WORD) && (off != 2'b00));
        return inv || bad_size || misalign;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_if
// Description : Request/response bus between a requester (master) and the
//               data memory responder (slave).
//               Request : reqValid/reqReady, reqWrite, physicalAddr, invAddr,
//                         byteOff, accSize, signExt, wData
//               Response: rspValid/rspReady, rData, rspErr
// Revision    : 1.0  initial release
// ============================================================================
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic               reqValid;
    logic               reqReady;
    logic               reqWrite;
    logic [DMEM_AW-1:0] physicalAddr;
    logic               invAddr;
    logic [1:0]         byteOff;
    logic [1:0]         accSize;
    logic               signExt;
    logic [31:0]        wData;
    logic               rspValid;
    logic               rspReady;
    logic [31:0]        rData;
    logic               rspErr;

    modport master (
        output reqValid, reqWrite, physicalAddr, invAddr, byteOff, accSize,
               signExt, wData, rspReady,
        input  reqReady, rspValid, rData, rspErr
    );

    modport slave (
        input  reqValid, reqWrite, physicalAddr, invAddr, byteOff, accSize,
               signExt, wData, rspReady,
        output reqReady, rspValid, rData, rspErr
    );

endinterface
`default_nettype wire

// File: rtl/data_mem_responder_ram.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ram
// Description : Single-port synchronous RAM, 32-bit words, no reset.
//               Read data appears the cycle after an enabled read; a write
//               takes effect at the clock edge.
// Ports       : clk, i_en (access enable), i_we (write), i_addr, i_wdata,
//               o_rdata
// Revision    : 1.0  initial release
// ============================================================================
module dmem_ram
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int AW    = DMEM_AW
) (
    input  wire logic          clk,
    input  wire logic          i_en,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_addr,
    input  wire logic [31:0]   i_wdata,
    output logic      [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Data memory responder. Accepts one load/store request at a
//               time, performs word stores directly, byte/half stores as a
//               read-modify-write, loads with lane selection and sign/zero
//               extension, and holds the response until it is taken.
// Ports       : clk, rst_n (async active-low), bus (slave modport)
// Revision    : 1.0  initial release
// ============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    data_mem_responder_if.slave bus
);

    state_t             r_state;
    state_t             w_next;

    // Captured request
    logic [DMEM_AW-1:0] r_addr;
    logic               r_write;
    logic [1:0]         r_off;
    logic [1:0]         r_size;
    logic               r_sext;
    logic [15:0]        r_wdata;

    logic [31:0]        r_merged;
    logic [31:0]        r_rdata;
    logic               r_err;

    logic               w_accept;
    logic               w_req_err;
    logic               w_word_store;
    logic               w_ram_en;
    logic               w_ram_we;
    logic [DMEM_AW-1:0] w_ram_addr;
    logic [31:0]        w_ram_wdata;
    logic [31:0]        w_ram_rdata;
    logic [31:0]        w_merged;
    logic [31:0]        w_load;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;

    assign w_accept     = bus.reqValid && (r_state == IDLE);
    assign w_req_err    = req_is_error(bus.invAddr, bus.accSize, bus.byteOff);
    assign w_word_store = bus.reqWrite && (bus.accSize == SZ_WORD);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // In IDLE the RAM is driven straight from the bus so the read (or word
    // write) happens on the acceptance edge; later states use the captured
    // address. Error requests never enable the RAM.
    always_comb begin
        w_next      = r_state;
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = r_addr;
        w_ram_wdata = r_merged;
        case (r_state)
            IDLE: begin
                w_ram_addr  = bus.physicalAddr;
                w_ram_wdata = bus.wData;
                if (w_accept) begin
                    if (w_req_err) begin
                        w_next = RESP;
                    end else if (w_word_store) begin
                        w_ram_en = 1'b1;
                        w_ram_we = 1'b1;
                        w_next   = RESP;
                    end else begin
                        w_ram_en = 1'b1;
                        w_next   = RD;
                    end
                end
            end
            RD: begin
                w_next = r_write ? MERGE : RESP;
            end
            MERGE: begin
                w_ram_en = 1'b1;
                w_ram_we = 1'b1;
                w_next   = RESP;
            end
            RESP: begin
                if (bus.rspReady) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Merge and load extension (operate on RAM read data during RD)
    // ------------------------------------------------------------------
    always_comb begin
        w_merged = w_ram_rdata;
        if (r_size == SZ_BYTE) begin
            w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merged[{r_off[1], 4'b0000} +: 16] = r_wdata;
        end
    end

    always_comb begin
        w_byte = w_ram_rdata[{r_off, 3'b000} +: 8];
        w_half = w_ram_rdata[{r_off[1], 4'b0000} +: 16];
        case (r_size)
            SZ_BYTE: w_load = {{24{r_sext & w_byte[7]}}, w_byte};
            SZ_HALF: w_load = {{16{r_sext & w_half[15]}}, w_half};
            default: w_load = w_ram_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_off    <= 2'b00;
            r_size   <= 2'b00;
            r_sext   <= 1'b0;
            r_wdata  <= '0;
            r_merged <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= bus.physicalAddr;
                r_write <= bus.reqWrite;
                r_off   <= bus.byteOff;
                r_size  <= bus.accSize;
                r_sext  <= bus.signExt;
                r_wdata <= bus.wData[15:0];
                r_err   <= w_req_err;
                // Stores and errors respond with zero data.
                r_rdata <= '0;
            end
            if (r_state == RD) begin
                if (r_write) begin
                    r_merged <= w_merged;
                end else begin
                    r_rdata <= w_load;
                end
            end
        end
    end

    assign bus.reqReady = (r_state == IDLE);
    assign bus.rspValid = (r_state == RESP);
    assign bus.rData    = r_rdata;
    assign bus.rspErr   = r_err;

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (DMEM_AW)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder. Expected
//               responses are queued when a request is driven and compared
//               when the response appears.
// Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct {
        logic        wr;
        logic [10:0] addr;
        logic        inv;
        logic [1:0]  off;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] wd;
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat;
    } req_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    data_mem_responder_if bus ();

    data_mem_responder #(.DEPTH(2048)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Drive one request, push its expectation, wait (bounded) for the
    // response, optionally hold it under backpressure, then take it.
    task automatic issue(input req_t r, input int hold,
                         output logic [31:0] o_rd, output logic o_err,
                         output int o_lat, output logic o_stable,
                         output logic o_rdy);
        exp_t e;
        @(negedge clk);
        bus.reqWrite     = r.wr;
        bus.physicalAddr = r.addr;
        bus.invAddr      = r.inv;
        bus.byteOff      = r.off;
        bus.accSize      = r.sz;
        bus.signExt      = r.sx;
        bus.wData        = r.wd;
        bus.reqValid     = 1'b1;
        e.rd = r.e_rd; e.err = r.e_err; e.lat = r.e_lat;
        sb.push_back(e);
        o_rdy = bus.reqReady;
        @(posedge clk); #1;
        bus.reqValid = 1'b0;
        o_lat = 1;
        while (bus.rspValid !== 1'b1 && o_lat < 20) begin
            @(posedge clk); #1;
            o_lat++;
        end
        o_rd     = bus.rData;
        o_err    = bus.rspErr;
        o_stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (bus.rspValid !== 1'b1 || bus.rData !== o_rd ||
                bus.rspErr !== o_err || bus.reqReady !== 1'b0)
                o_stable = 1'b0;
        end
        bus.rspReady = 1'b1;
        @(posedge clk); #1;
        bus.rspReady = 1'b0;
    endtask

    task automatic test_reset();
        bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.physicalAddr = '0;
        bus.invAddr = 1'b0; bus.byteOff = 2'b00; bus.accSize = SZ_WORD;
        bus.signExt = 1'b0; bus.wData = '0; bus.rspReady = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.reqReady !== 1'b1) begin n_fail++; $display("FAIL reset_reqReady got %b want 1", bus.reqReady); end
        n_checks++; if (bus.rspValid !== 1'b0) begin n_fail++; $display("FAIL reset_rspValid got %b want 0", bus.rspValid); end
        n_checks++; if (bus.rData !== 32'h0) begin n_fail++; $display("FAIL reset_rData got %h want 0", bus.rData); end
        n_checks++; if (bus.rspErr !== 1'b0) begin n_fail++; $display("FAIL reset_rspErr got %b want 0", bus.rspErr); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.reqReady !== 1'b1 || bus.rspValid !== 1'b0) begin n_fail++; $display("FAIL reset_hold got rdy=%b vld=%b want 1/0", bus.reqReady, bus.rspValid); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        req_t t[$];
        exp_t e;
        logic [31:0] rd; logic er, st, rdy; int lat;
        t.push_back('{1'b1, 11'h005, 1'b0, 2'd0, SZ_WORD, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 1});
        t.push_back('{1'b0, 11'h005, 1'b0, 2'd0, SZ_WORD, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 2});
        foreach (t[i]) begin
            issue(t[i], 0, rd, er, lat, st, rdy);
            e = sb.pop_front();
            n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL word[%0d]_reqReady got %b want 1", i, rdy); end
            n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL word[%0d]_latency got %0d want %0d", i, lat, e.lat); end
            n_checks++; if (er !== e.err) begin n_fail++; $display("FAIL word[%0d]_rspErr got %b want %b", i, er, e.err); end
            n_checks++; if (rd !== e.rd) begin n_fail++; $display("FAIL word[%0d]_rData got %h want %h", i, rd, e.rd); end
        end
    endtask

    task automatic test_byte_rmw();
        req_t t[$];
        exp_t e;
        logic [31:0] rd; logic er, st, rdy; int lat;
        t.push_back('{1'b1, 11'h010, 1'b0, 2'd0, SZ_WORD, 1'b0, 32'h11223344, 32'h0, 1'b0, 1});
        t.push_back('{1'b1, 11'h010, 1'b0, 2'd2, SZ_BYTE, 1'b0, 32'h123456AA, 32'h0, 1'b0, 3});
        t.push_back('{1'b0, 11'h010, 1'b0, 2'd0, SZ_WORD, 1'b0, 32'h0, 32'h11AA3344, 1'b0, 2});
        t.push_back('{1'b0, 11'h010, 1'b0, 2'd2, SZ_BYTE, 1'b1, 32'h0, 32'hFFFFFFAA, 1'b0, 2});
        t.push_back('{1'b0, 11'h010, 1'b0, 2'd2, SZ_BYTE, 1'b0, 32'h0, 32'h000000AA, 1'b0, 2});
        t.push_back('{1'b0, 11'h010, 1'b0, 2'd3, SZ_BYTE, 1'b1, 32'h0, 32'h00000011, 1'b0, 2});
        t.push_back('{1'b0, 11'h010, 1'b0, 2'd0, SZ_BYTE, 1'b1, 32'h0, 32'h00000044, 1'b0, 2});
        foreach (t[i]) begin
            issue(t[i], 0, rd, er, lat, st, rdy);
            e = sb.pop_front();
            n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL byte[%0d]_latency got %0d want %0d", i, lat, e.lat); end
            n_checks++; if (er !== e.err) begin n_fail++; $display("FAIL byte[%0d]_rspErr got %b want %b", i, er, e.err); end
            n_checks++; if (rd !== e.rd) begin n_fail++; $display("FAIL byte[%0d]_rData got %h want %h", i, rd, e.rd); end
        end
    endtask

    task automatic test_half();
        req_t t[$];
        exp_t e;
        logic [31:0] rd; logic er, st, rdy; int lat;
        t.push_back('{1'b1, 11'h7FF, 1'b0, 2'd0, SZ_WORD, 1'b0, 32'h12345678, 32'h0, 1'b0, 1});
        t.push_back('{1'b1, 11'h7FF, 1'b0, 2'd2, SZ_HALF, 1'b0, 32'hABCD8001, 32'h0, 1'b0, 3});
        t.push_back('{1'b0, 11'h7FF, 1'b0, 2'd2, SZ_HALF, 1'b1, 32'h0, 32'hFFFF8001, 1'b0, 2});
        t.push_back('{1'b0, 11'h7FF, 1'b0, 2'd2, SZ_HALF, 1'b0, 32'h0, 32'h00008001, 1'b0, 2});
        t.push_back('{1'b0, 11'h7FF, 1'b0, 2'd0, SZ_HALF, 1'b1, 32'h0, 32'h00005678, 1'b0, 2});
        t.push_back('{1'b0, 11'h7FF, 1'b0, 2'd0, SZ_WORD, 1'b0, 32'h0, 32'h80015678, 1'b0, 2});
        t.push_back('{1'b1, 11'h7FF, 1'b0, 2'd0, SZ_HALF, 1'b0, 32'h0000F00F, 32'h0, 1'b0, 3});
        t.push_back('{1'b0, 11'h7FF, 1'b0, 2'd0, SZ_WORD, 1'b0, 32'h0, 32'h8001F00F, 1'b0, 2});
        foreach (t[i]) begin
            issue(t[i], 0, rd, er, lat, st, rdy);
            e = sb.pop_front();
            n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL half[%0d]_latency got %0d want %0d", i, lat, e.lat); end
            n_checks++; if (er !== e.err) begin n_fail++; $display("FAIL half[%0d]_rspErr got %b want %b", i, er, e.err); end
            n_checks++; if (rd !== e.rd) begin n_fail++; $display("FAIL half[%0d]_rData got %h want %h", i, rd, e.rd); end
        end
    endtask

    task automatic test_errors();
        req_t t[$];
        exp_t e;
        logic [31:0] rd; logic er, st, rdy; int lat;
        t.push_back('{1'b1, 11'h010, 1'b1, 2'd0, SZ_WORD, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1});
        t.push_back('{0, 11'h010, 1'b0, 2'd1, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b1, 1});
        t.push_back('{1'b1, 11'h010, 1'b0, 2'd0, 2'b11, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1});
        t.push_back('{1'b0, 11'h010, 1'b0, 2'd1, SZ_HALF, 1'b1, 32'h0, 32'h0, 1'b1, 1});
        t.push_back('{1'b1, 11'h010, 1'b0, 2'd3, SZ_HALF, 1'b0, 32'h0000FFFF, 32'h0, 1'b1, 1});
        t.push_back('{1'b1, 11'h010, 1'b0, 2'd2, SZ_WORD, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1});
        t.push_back('{1'b0, 11'h010, 1'b1, 2'd0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b1, 1});
        t.push_back('{1'b0, 11'h010, 1'b0, 2'd0, SZ_WORD, 1'b0, 32'h0, 32'h11AA3344, 1'b0, 2});
        foreach (t[i]) begin
            issue(t[i], 0, rd, er, lat, st, rdy);
            e = sb.pop_front();
            n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL err[%0d]_latency got %0d want %0d", i, lat, e.lat); end
            n_checks++; if (er !== e.err) begin n_fail++; $display("FAIL err[%0d]_rspErr got %b want %b", i, er, e.err); end
            n_checks++; if (rd !== e.rd) begin n_fail++; $display("FAIL err[%0d]_rData got %h want %h", i, rd, e.rd); end
        end
    endtask

    task automatic test_backpressure();
        req_t r;
        exp_t e;
        logic [31:0] rd; logic er, st, rdy; int lat;
        r = '{1'b0, 11'h005, 1'b0, 2'd0, SZ_WORD, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 2};
        issue(r, 5, rd, er, lat, st, rdy);
        e = sb.pop_front();
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL bp_stable got %b want 1", st); end
        n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL bp_latency got %0d want %0d", lat, e.lat); end
        n_checks++; if (rd !== e.rd) begin n_fail++; $display("FAIL bp_rData got %h want %h", rd, e.rd); end
        n_checks++; if (bus.rspValid !== 1'b0 || bus.reqReady !== 1'b1) begin n_fail++; $display("FAIL bp_release got vld=%b rdy=%b want 0/1", bus.rspValid, bus.reqReady); end
    endtask

    task automatic test_back_to_back();
        req_t t[$];
        exp_t e;
        logic [31:0] data [6];
        logic [31:0] rd; logic er, st, rdy; int lat;
        for (int i = 0; i < 6; i++) begin
            data[i] = $urandom();
            t.push_back('{1'b1, 11'h100 + 11'(i), 1'b0, 2'd0, SZ_WORD, 1'b0, data[i], 32'h0, 1'b0, 1});
        end
        for (int i = 0; i < 6; i++)
            t.push_back('{1'b0, 11'h100 + 11'(i), 1'b0, 2'd0, SZ_WORD, 1'b0, 32'h0, data[i], 1'b0, 2});
        foreach (t[i]) begin
            issue(t[i], 0, rd, er, lat, st, rdy);
            e = sb.pop_front();
            n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL b2b[%0d]_reqReady got %b want 1", i, rdy); end
            n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL b2b[%0d]_latency got %0d want %0d", i, lat, e.lat); end
            n_checks++; if (rd !== e.rd) begin n_fail++; $display("FAIL b2b[%0d]_rData got %h want %h", i, rd, e.rd); end
        end
        // A request held high across the response handshake must wait for IDLE.
        @(negedge clk);
        bus.reqWrite = 1'b1; bus.physicalAddr = 11'h200; bus.invAddr = 1'b0;
        bus.byteOff = 2'd0; bus.accSize = SZ_WORD; bus.signExt = 1'b0;
        bus.wData = 32'h0BADF00D; bus.reqValid = 1'b1;
        @(posedge clk); #1;
        bus.reqWrite = 1'b0; bus.rspReady = 1'b1;
        sb.push_back('{32'h0BADF00D, 1'b0, 2});
        n_checks++; if (bus.rspValid !== 1'b1) begin n_fail++; $display("FAIL b2b_store_rsp got %b want 1", bus.rspValid); end
        @(posedge clk); #1;
        bus.rspReady = 1'b0;
        n_checks++; if (bus.rspValid !== 1'b0 || bus.reqReady !== 1'b1) begin n_fail++; $display("FAIL b2b_no_accept_on_handshake got vld=%b rdy=%b want 0/1", bus.rspValid, bus.reqReady); end
        @(posedge clk); #1;
        bus.reqValid = 1'b0;
        n_checks++; if (bus.reqReady !== 1'b0 || bus.rspValid !== 1'b0) begin n_fail++; $display("FAIL b2b_accept_after_idle got rdy=%b vld=%b want 0/0", bus.reqReady, bus.rspValid); end
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++; if (bus.rspValid !== 1'b1 || bus.rData !== e.rd) begin n_fail++; $display("FAIL b2b_load_after got vld=%b data=%h want 1/%h", bus.rspValid, bus.rData, e.rd); end
        bus.rspReady = 1'b1;
        @(posedge clk); #1;
        bus.rspReady = 1'b0;
    endtask

    task automatic test_reset_mid_rmw();
        req_t r;
        exp_t e;
        logic [31:0] rd; logic er, st, rdy; int lat;
        r = '{1'b1, 11'h020, 1'b0, 2'd0, SZ_WORD, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0, 1};
        issue(r, 0, rd, er, lat, st, rdy);
        e = sb.pop_front();
        n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL rst_preload_latency got %0d want %0d", lat, e.lat); end
        @(negedge clk);
        bus.reqWrite = 1'b1; bus.physicalAddr = 11'h020; bus.invAddr = 1'b0;
        bus.byteOff = 2'd1; bus.accSize = SZ_BYTE; bus.signExt = 1'b0;
        bus.wData = 32'h00000055; bus.reqValid = 1'b1;
        @(posedge clk); #1;
        bus.reqValid = 1'b0;
        n_checks++; if (bus.reqReady !== 1'b0) begin n_fail++; $display("FAIL rst_in_rd got reqReady=%b want 0", bus.reqReady); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.reqReady !== 1'b1 || bus.rspValid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_handshake got rdy=%b vld=%b want 1/0", bus.reqReady, bus.rspValid); end
        n_checks++; if (bus.rData !== 32'h0 || bus.rspErr !== 1'b0) begin n_fail++; $display("FAIL rst_mid_data got %h/%b want 0/0", bus.rData, bus.rspErr); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        r = '{1'b0, 11'h020, 1'b0, 2'd0, SZ_WORD, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 2};
        issue(r, 0, rd, er, lat, st, rdy);
        e = sb.pop_front();
        n_checks++; if (rd !== e.rd) begin n_fail++; $display("FAIL rst_word_unchanged got %h want %h", rd, e.rd); end
        n_checks++; if (lat != e.lat) begin n_fail++; $display("FAIL rst_load_latency got %0d want %0d", lat, e.lat); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_rmw();
        test_half();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_rmw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
